// File: rtl/key_pkg.sv
// Shared definitions for the active-low key debouncer: per-channel FSM states
// and the default filter length (20 ms at 50 MHz).
package key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_FILT   = 2'd1,
        ST_DOWN         = 2'd2,
        ST_RELEASE_FILT = 2'd3
    } key_state_t;

    localparam logic [31:0] CNT_MAX_DEFAULT = 32'd999_999;

endpackage

// File: rtl/key_filter_ch.sv
// One debounce channel: two-flop synchroniser, stability counter and FSM
// producing a registered level plus one-cycle press/release pulses.
module key_filter_ch
    import key_pkg::*;
#(
    parameter logic [31:0] CNT_MAX = CNT_MAX_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic n_key,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    logic        sync1;
    logic        sync2;
    logic [31:0] cnt;
    key_state_t  state;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= n_key;
            sync2 <= sync1;
        end
    end

    // key_level tracks the state being entered, so it moves with the pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            case (state)
                ST_IDLE: begin
                    key_level <= 1'b0;
                    if (!sync2) begin
                        state <= ST_PRESS_FILT;
                        cnt   <= '0;
                    end
                end
                ST_PRESS_FILT: begin
                    if (sync2) begin
                        state     <= ST_IDLE;
                        cnt       <= '0;
                        key_level <= 1'b0;
                    end else if (cnt == CNT_MAX) begin
                        state     <= ST_DOWN;
                        cnt       <= '0;
                        key_level <= 1'b1;
                        key_press <= 1'b1;
                    end else begin
                        cnt       <= cnt + 32'd1;
                        key_level <= 1'b0;
                    end
                end
                ST_DOWN: begin
                    key_level <= 1'b1;
                    if (sync2) begin
                        state <= ST_RELEASE_FILT;
                        cnt   <= '0;
                    end
                end
                ST_RELEASE_FILT: begin
                    if (!sync2) begin
                        state     <= ST_DOWN;
                        cnt       <= '0;
                        key_level <= 1'b1;
                    end else if (cnt == CNT_MAX) begin
                        state       <= ST_IDLE;
                        cnt         <= '0;
                        key_level   <= 1'b0;
                        key_release <= 1'b1;
                    end else begin
                        cnt       <= cnt + 32'd1;
                        key_level <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cnt       <= '0;
                    key_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_filter_4.sv
// Four independent debounce channels for the active-low push keys; outputs
// are active high.
module key_filter_4
    import key_pkg::*;
#(
    parameter logic [31:0] CNT_MAX = CNT_MAX_DEFAULT,
    parameter int          KEY_NUM = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_NUM-1:0] n_key_in,
    output logic [KEY_NUM-1:0] key_level,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release
);

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        key_filter_ch #(
            .CNT_MAX (CNT_MAX)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .n_key       (n_key_in[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i])
        );
    end

endmodule

// File: tb/tb_key_filter_4.sv
// Scoreboard bench for key_filter_4: a run-length model of the acceptance
// rule predicts pulses and levels; a negedge monitor checks the DUT.
module tb_key_filter_4;

    localparam int unsigned CM    = 24;
    localparam int          NCYC  = 8192;

    typedef struct {
        int         cyc;
        logic [3:0] pr;
        logic [3:0] rl;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] n_key_in;
    logic [3:0] key_level;
    logic [3:0] key_press;
    logic [3:0] key_release;

    int tests = 0;
    int fails = 0;
    int edge_n = 0;
    int mon_n = 0;

    ev_t        evq[$];
    logic [3:0] exp_lvl [NCYC];

    // model state: accepted level and run of samples disagreeing with it
    logic [3:0]  m_lvl;
    int unsigned m_run [4];

    key_filter_4 #(
        .CNT_MAX (32'd24),
        .KEY_NUM (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .n_key_in    (n_key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release)
    );

    always #10 clk = ~clk;

    task automatic model_edge(input logic r, input logic [3:0] k);
        int         e;
        logic [3:0] pr;
        logic [3:0] rl;
        logic       p;
        e  = edge_n;
        pr = '0;
        rl = '0;
        if (r) begin
            m_lvl = '0;
            for (int c = 0; c < 4; c++) m_run[c] = 0;
            for (int d = 0; d < 3; d++) if (e + d < NCYC) exp_lvl[e + d] = '0;
            while (evq.size() > 0 && evq[$].cyc >= e) void'(evq.pop_back());
        end else begin
            for (int c = 0; c < 4; c++) begin
                p = ~k[c];
                if (p != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == CM + 2) begin
                        m_lvl[c] = p;
                        m_run[c] = 0;
                        if (p) pr[c] = 1'b1;
                        else   rl[c] = 1'b1;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            if (e + 2 < NCYC) exp_lvl[e + 2] = m_lvl;
            if ((pr | rl) != 4'b0) evq.push_back('{cyc: e + 2, pr: pr, rl: rl});
        end
    endtask

    task automatic tick(input logic r, input logic [3:0] k);
        rst      = r;
        n_key_in = k;
        @(posedge clk);
        edge_n++;
        model_edge(r, k);
        #1;
    endtask

    task automatic hold(input int n, input logic r, input logic [3:0] k);
        for (int i = 0; i < n; i++) tick(r, k);
    endtask

    // monitor: level every cycle, pulses popped from the scoreboard
    initial begin
        ev_t ev;
        forever begin
            @(negedge clk);
            mon_n++;
            tests++;
            if (mon_n < NCYC && key_level !== exp_lvl[mon_n]) begin
                fails++;
                $display("FAIL level cyc=%0d got=%b exp=%b", mon_n, key_level, exp_lvl[mon_n]);
            end
            while (evq.size() > 0 && evq[0].cyc < mon_n) begin
                ev = evq.pop_front();
                tests++;
                fails++;
                $display("FAIL missed_pulse cyc=%0d got=none exp=press %b release %b", ev.cyc, ev.pr, ev.rl);
            end
            if ((key_press | key_release) !== 4'b0) begin
                tests++;
                if (evq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pulse cyc=%0d got=press %b release %b exp=none", mon_n, key_press, key_release);
                end else begin
                    ev = evq.pop_front();
                    if (ev.cyc != mon_n || key_press !== ev.pr || key_release !== ev.rl) begin
                        fails++;
                        $display("FAIL pulse cyc=%0d got=press %b release %b exp=cyc %0d press %b release %b",
                                 mon_n, key_press, key_release, ev.cyc, ev.pr, ev.rl);
                    end
                end
            end else if (evq.size() > 0 && evq[0].cyc == mon_n) begin
                ev = evq.pop_front();
                tests++;
                fails++;
                $display("FAIL missed_pulse cyc=%0d got=none exp=press %b release %b", ev.cyc, ev.pr, ev.rl);
            end
        end
    end

    initial begin
        logic [3:0]  kv;
        int unsigned left [4];
        logic        r;
        m_lvl = '0;
        for (int c = 0; c < 4; c++) m_run[c] = 0;
        for (int i = 0; i < NCYC; i++) exp_lvl[i] = '0;

        // reset then quiet
        hold(3, 1'b1, 4'hF);
        hold(100, 1'b0, 4'hF);
        // clean press/release on key 0
        hold(200, 1'b0, 4'b1110);
        hold(100, 1'b0, 4'hF);
        // key 1 boundary: 25 low samples rejected, 26 accepted
        hold(25, 1'b0, 4'b1101);
        hold(60, 1'b0, 4'hF);
        hold(26, 1'b0, 4'b1101);
        hold(60, 1'b0, 4'hF);
        // key 2 bounce then stable low
        for (int i = 0; i < 20; i++) hold(3, 1'b0, (i % 2 == 0) ? 4'b1011 : 4'hF);
        hold(60, 1'b0, 4'b1011);
        hold(60, 1'b0, 4'hF);
        // keys 0 and 3 together
        hold(60, 1'b0, 4'b0110);
        hold(60, 1'b0, 4'hF);
        // reset while key 1 held down
        hold(60, 1'b0, 4'b1101);
        hold(1, 1'b1, 4'b1101);
        hold(60, 1'b0, 4'b1101);
        hold(60, 1'b0, 4'hF);

        // random: per-key segments of random length, clustered near the threshold
        kv = 4'hF;
        for (int c = 0; c < 4; c++) left[c] = 0;
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < 4; c++) begin
                if (left[c] == 0) begin
                    kv[c]   = ~kv[c];
                    left[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 80) : $urandom_range(22, 29);
                end
                left[c]--;
            end
            r = ($urandom_range(0, 999) == 0);
            tick(r, kv);
        end
        hold(80, 1'b0, 4'hF);

        tests++;
        if (evq.size() != 0) begin
            fails++;
            $display("FAIL pending_events got=%0d exp=0", evq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/key_filter_4.md
# key_filter_4

Four-channel debouncer for the board's active-low push keys: the input-side counterpart to the active-low LED drivers. Each raw key pin is synchronised, filtered by a per-key counter and state machine, and presented as a clean active-high level plus single-cycle press and release pulses. Downstream control logic, such as LED pattern or mode selection, consumes the pulses.

## Interface
- `CNT_MAX`, default 32'd999_999: filter length in clock cycles minus one. The default gives 20 ms at 50 MHz. Simulation uses 32'd24.
- `KEY_NUM`, default 4: number of key channels. Fixed at 4 in this release.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `n_key_in`  in  4  raw key pins, active low (0 = pressed), asynchronous to `clk`, bouncy.
- `key_level`  out  4  debounced state, active high (1 = pressed).
- `key_press`  out  4  one-cycle pulse per accepted press.
- `key_release`  out  4  one-cycle pulse per accepted release.

## Operation
- Channels are fully independent. Everything below applies per bit i.
- **Synchroniser:** two flops, `sync1`→`sync2`. Both reset to 1 (released). `s` = `sync2`.
- **Counter:** `cnt` is 32-bit unsigned and resets to 0. It never wraps, because it is cleared at CNT_MAX.
- **FSM states:** IDLE (released, stable), PRESS_FILT, DOWN (pressed, stable), RELEASE_FILT. Reset state is IDLE.
- **Transitions, evaluated each edge:**
  - IDLE: if s==0, go to PRESS_FILT with cnt=0. Otherwise hold.
  - PRESS_FILT:
    - if s==1, go to IDLE with cnt=0 (bounce rejected);
    - else if cnt==CNT_MAX, go to DOWN, set cnt=0, and set `key_press`=1;
    - else cnt+1.
  - DOWN: if s==1, go to RELEASE_FILT with cnt=0. Otherwise hold.
  - RELEASE_FILT:
    - if s==0, go to DOWN with cnt=0;
    - else if cnt==CNT_MAX, go to IDLE, set cnt=0, and set `key_release`=1;
    - else cnt+1.
- **`key_level`:** registered. It is 1 when the next state is DOWN or RELEASE_FILT, and 0 otherwise. It rises in the same cycle as `key_press` and falls in the same cycle as `key_release`.
- **Pulse outputs:** `key_press` and `key_release` are registered and default to 0 every cycle. They are never high together on one channel.
- **Reset mid-operation:** state, counters and outputs clear and the synchronisers reload 1. A key still held when `rst` deasserts is treated as a fresh press: `key_press` fires after the full latency.
- **Partial or no press:** a press that never completes the filter produces no pulse and leaves `key_level` at 0.

## Timing
- **Reset values:** `key_level`=0, `key_press`=0, `key_release`=0, sync flops=1, cnt=0, state=IDLE.
- **Acceptance rule:** a press is accepted if and only if `n_key_in` is sampled low on at least CNT_MAX+2 consecutive edges. Exactly CNT_MAX+1 low samples is rejected. Release uses the symmetric rule on high samples.
- **Press latency:** let E0 be the first edge that samples low. `key_press` and the rising `key_level` appear after edge E0+CNT_MAX+3. With CNT_MAX=24 that is 27 edges. Release latency is identical.
- **Pulse width:** exactly one `clk` cycle, regardless of how long the key is held.
- **Simultaneous events:** channels pressing or releasing on the same edge produce their pulses in the same cycle. There is no arbitration.
- **Re-press inside the release filter:** the channel returns to DOWN with no pulse, and `key_level` stays 1 throughout.

## Structure
- **Shared package `key_pkg`:**
  - 2-bit state encodings: ST_IDLE=2'd0, ST_PRESS_FILT=2'd1, ST_DOWN=2'd2, ST_RELEASE_FILT=2'd3.
  - Default CNT_MAX constant.
- **Sub-module `key_filter_ch`:** one channel, containing the synchroniser, counter, FSM and three output registers. It takes the CNT_MAX parameter.
- **Top `key_filter_4`:** instantiates four copies of `key_filter_ch` via generate and concatenates their outputs. It has no logic of its own.

## Test plan
All scenarios use CNT_MAX=24 and a 50 MHz `clk`.
- **Reset:** with `rst`=1 for 3 cycles and all keys high → all outputs 0. No pulse for 100 cycles after release.
- **Clean press on key 0:** hold `n_key_in`[0] low for 200 cycles → `key_press`[0] high for exactly 1 cycle, 27 edges after the first low sample; `key_level`[0]=1 from then on. Return high → `key_release`[0] fires 27 edges later and `key_level`[0]=0.
- **Boundary glitch on key 1:** a low pulse of 25 samples → no pulse and `key_level`[1] stays 0. A low pulse of 26 samples → exactly one `key_press`[1].
- **Bounce:** on key 2, toggle every 3 cycles for 60 cycles, then hold low → exactly one `key_press`[2], 27 edges after the start of the final stable low.
- **Simultaneous keys:** press keys 0 and 3 on the same edge → `key_press`=4'b1001 in a single cycle.
- **Reset while held:** key 1 is in DOWN; assert `rst` for 1 cycle with the key still low → `key_level`[1] drops to 0 with no release pulse. `key_press`[1] re-fires 27 edges after `rst` deasserts.
